// File: rtl/sram_port_arbiter_if.sv
// Requester/RAM-side bundle for the two-port SRAM arbiter.
// Ports: req0/req1 access requests with grant and rvalid back, shared rd_data,
// arb_en gate, and the registered single-port RAM command/read-data signals.
// slave modport = arbiter side, master modport = requesters + RAM side.
interface sram_port_arbiter_if;
  logic        arb_en;
  logic        req0_valid, req1_valid;
  logic        req0_we,    req1_we;
  logic [12:0] req0_addr,  req1_addr;
  logic [15:0] req0_wdata, req1_wdata;
  logic [15:0] req0_wmask, req1_wmask;
  logic        req0_grant, req1_grant;
  logic        req0_rvalid, req1_rvalid;
  logic [15:0] rd_data;
  logic [12:0] ram_raddr, ram_waddr;
  logic        ram_we;
  logic [15:0] ram_wdata, ram_wmask;
  logic [15:0] ram_rdata;

  modport slave (
    input  arb_en,
    input  req0_valid, req1_valid, req0_we, req1_we,
    input  req0_addr, req1_addr, req0_wdata, req1_wdata, req0_wmask, req1_wmask,
    output req0_grant, req1_grant, req0_rvalid, req1_rvalid, rd_data,
    output ram_raddr, ram_waddr, ram_we, ram_wdata, ram_wmask,
    input  ram_rdata
  );

  modport master (
    output arb_en,
    output req0_valid, req1_valid, req0_we, req1_we,
    output req0_addr, req1_addr, req0_wdata, req1_wdata, req0_wmask, req1_wmask,
    input  req0_grant, req1_grant, req0_rvalid, req1_rvalid, rd_data,
    input  ram_raddr, ram_waddr, ram_we, ram_wdata, ram_wmask,
    output ram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: arbitrates two requesters onto one synchronous SRAM port (round-robin).
// Latency: grant combinational in T, RAM command in T+1, read rvalid in T+2.
// Backpressure: none on rvalid; arb_en low or reset blocks new grants only.
// Ports: clk, rst_n (synchronous, active-low), bus (sram_port_arbiter_if.slave).
// Config: define ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module sram_port_arbiter (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_port_arbiter_if.slave    bus
);

  logic        grant0, grant1;
  logic        any_grant;
  logic        sel_we;
  logic [12:0] sel_addr;
  logic [15:0] sel_wdata, sel_wmask;

  logic        ram_we_q;
  logic [12:0] ram_raddr_q, ram_waddr_q;
  logic [15:0] ram_wdata_q, ram_wmask_q;
  logic        rd_tag_vld;   // a read command is on the RAM port this cycle
  logic        rd_tag_id;    // requester that owns it
  logic        rvalid0_q, rvalid1_q;

`ifndef ARB_FIXED_PRIO_EN
  logic        last_grant;   // 1 = requester 1 was granted most recently
`endif

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && bus.arb_en) begin
`ifdef ARB_FIXED_PRIO_EN
      if (bus.req0_valid)      grant0 = 1'b1;
      else if (bus.req1_valid) grant1 = 1'b1;
`else
      if (bus.req0_valid && bus.req1_valid) begin
        // contention: the requester not served last time wins
        if (last_grant) grant0 = 1'b1;
        else            grant1 = 1'b1;
      end else if (bus.req0_valid) begin
        grant0 = 1'b1;
      end else if (bus.req1_valid) begin
        grant1 = 1'b1;
      end
`endif
    end
  end

  assign any_grant = grant0 | grant1;
  assign sel_we    = grant1 ? bus.req1_we    : bus.req0_we;
  assign sel_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
  assign sel_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
  assign sel_wmask = grant1 ? bus.req1_wmask : bus.req0_wmask;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we_q    <= 1'b0;
      ram_raddr_q <= '0;
      ram_waddr_q <= '0;
      ram_wdata_q <= '0;
      ram_wmask_q <= '0;
      rd_tag_vld  <= 1'b0;
      rd_tag_id   <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      last_grant  <= 1'b1;
`endif
    end else begin
      ram_we_q   <= any_grant & sel_we;
      rd_tag_vld <= any_grant & ~sel_we;
      if (any_grant) begin
        rd_tag_id <= grant1;
        if (sel_we) begin
          ram_waddr_q <= sel_addr;
          ram_wdata_q <= sel_wdata;
          ram_wmask_q <= sel_wmask;
        end else begin
          ram_raddr_q <= sel_addr;
        end
      end
      // RAM returns data the cycle after the address, so rvalid trails the tag by one
      rvalid0_q <= rd_tag_vld & ~rd_tag_id;
      rvalid1_q <= rd_tag_vld &  rd_tag_id;
`ifndef ARB_FIXED_PRIO_EN
      if (any_grant) last_grant <= grant1;
`endif
    end
  end

  assign bus.req0_grant  = grant0;
  assign bus.req1_grant  = grant1;
  assign bus.req0_rvalid = rvalid0_q;
  assign bus.req1_rvalid = rvalid1_q;
  assign bus.rd_data     = bus.ram_rdata;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_raddr   = ram_raddr_q;
  assign bus.ram_waddr   = ram_waddr_q;
  assign bus.ram_wdata   = ram_wdata_q;
  assign bus.ram_wmask   = ram_wmask_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed requests, behavioural SRAM, and a
// scoreboard of expected reads (requester, data, cycle) popped by a monitor.
module tb_sram_port_arbiter;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  sram_port_arbiter_if bus();

  sram_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        id;
    logic [15:0] data;
    int          at;
  } rd_exp_t;

  rd_exp_t sb[$];
  logic [15:0] mem [0:8191];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural SRAM: mask bit 0 means the bit is written; read is registered.
  always @(posedge clk) begin
    if (bus.ram_we)
      mem[bus.ram_waddr] <= (mem[bus.ram_waddr] & bus.ram_wmask) | (bus.ram_wdata & ~bus.ram_wmask);
    bus.ram_rdata <= mem[bus.ram_raddr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every rvalid must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.req0_rvalid || bus.req1_rvalid) begin
        if (bus.req0_rvalid && bus.req1_rvalid) begin
          chk("rvalid_both", 32'd1, 32'd0);
        end else if (sb.size() == 0) begin
          chk("rvalid_unexpected", {31'd0, bus.req1_rvalid}, 32'hFFFF_FFFF);
        end else begin
          rd_exp_t e;
          e = sb.pop_front();
          chk("rvalid_id",    {31'd0, bus.req1_rvalid}, {31'd0, e.id});
          chk("rvalid_data",  {16'd0, bus.rd_data},     {16'd0, e.data});
          chk("rvalid_cycle", cyc,                      e.at);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic set_req(input int n, input logic we, input logic [12:0] a,
                         input logic [15:0] d, input logic [15:0] m);
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_we = we; bus.req0_addr = a;
      bus.req0_wdata = d;    bus.req0_wmask = m;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_we = we; bus.req1_addr = a;
      bus.req1_wdata = d;    bus.req1_wmask = m;
    end
  endtask

  task automatic push_rd(input logic id, input logic [15:0] d);
    rd_exp_t e;
    e.id = id; e.data = d; e.at = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    cyc = 0; checks = 0; errors = 0;
    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    mem[5] = 16'hBEEF;
    mem[6] = 16'h1234;
    bus.arb_en = 1'b1;
    bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_wmask = '0;
    bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_wmask = '0;
    // requests held during reset must not be granted
    set_req(0, 1'b1, 13'h0010, 16'h1111, 16'h0000);
    set_req(1, 1'b0, 13'h0011, 16'h0000, 16'h0000);
    rst_n = 1'b0;
    step();
    @(negedge clk);
    chk("rst_grant0", {31'd0, bus.req0_grant}, 0);
    chk("rst_grant1", {31'd0, bus.req1_grant}, 0);
    step();
    @(negedge clk);
    chk("rst_ram_we",  {31'd0, bus.ram_we}, 0);
    chk("rst_rvalid",  {30'd0, bus.req1_rvalid, bus.req0_rvalid}, 0);
    chk("rst_ram_bus", {bus.ram_raddr, bus.ram_waddr} | {bus.ram_wdata, bus.ram_wmask}, 0);
    step();
    idle_reqs();
    rst_n = 1'b1;
    step();

    // single read of 0x0005
    set_req(0, 1'b0, 13'h0005, 16'h0, 16'h0);
    @(negedge clk);
    chk("t1_grant0", {31'd0, bus.req0_grant}, 1);
    chk("t1_grant1", {31'd0, bus.req1_grant}, 0);
    push_rd(1'b0, 16'hBEEF);
    step();
    idle_reqs();
    @(negedge clk);
    chk("t1_raddr", {19'd0, bus.ram_raddr}, 32'h5);
    chk("t1_ram_we", {31'd0, bus.ram_we}, 0);
    step(); step(); step();

    // contention after reset, back-to-back reads
    do_reset();
    set_req(0, 1'b0, 13'h0005, 16'h0, 16'h0);
    set_req(1, 1'b0, 13'h0006, 16'h0, 16'h0);
    for (int k = 0; k < 4; k++) begin
      logic exp1;
`ifdef ARB_FIXED_PRIO_EN
      exp1 = 1'b0;
`else
      exp1 = (k % 2) == 1;
`endif
      @(negedge clk);
      chk("t2_grant0", {31'd0, bus.req0_grant}, {31'd0, ~exp1});
      chk("t2_grant1", {31'd0, bus.req1_grant}, {31'd0, exp1});
      push_rd(exp1, exp1 ? 16'h1234 : 16'hBEEF);
      step();
    end
    idle_reqs();
    step(); step(); step();

    // write then read-after-write at the top address
    set_req(1, 1'b1, 13'h1FFF, 16'hA5A5, 16'h0000);
    @(negedge clk);
    chk("t3_wgrant1", {31'd0, bus.req1_grant}, 1);
    step();
    idle_reqs();
    set_req(0, 1'b0, 13'h1FFF, 16'h0, 16'h0);
    @(negedge clk);
    chk("t3_rgrant0", {31'd0, bus.req0_grant}, 1);
    chk("t3_ram_we",  {31'd0, bus.ram_we}, 1);
    chk("t3_waddr",   {19'd0, bus.ram_waddr}, 32'h1FFF);
    chk("t3_wdata",   {16'd0, bus.ram_wdata}, 32'hA5A5);
    chk("t3_wmask",   {16'd0, bus.ram_wmask}, 32'h0000);
    push_rd(1'b0, 16'hA5A5);
    step();
    // partial mask: only the low byte is written with zeros
    set_req(0, 1'b1, 13'h1FFF, 16'h0000, 16'hFF00);
    @(negedge clk);
    chk("t3_raddr", {19'd0, bus.ram_raddr}, 32'h1FFF);
    chk("t3_we_after_read", {31'd0, bus.ram_we}, 0);
    step();
    set_req(0, 1'b0, 13'h1FFF, 16'h0, 16'h0);
    @(negedge clk);
    chk("t3_mask_out", {16'd0, bus.ram_wmask}, 32'hFF00);
    push_rd(1'b0, 16'hA500);
    step();
    idle_reqs();
    step(); step(); step();

    // arb_en low blocks everything
    bus.arb_en = 1'b0;
    set_req(0, 1'b1, 13'h0100, 16'h1111, 16'h0000);
    set_req(1, 1'b1, 13'h0100, 16'h1111, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_blocked", {29'd0, bus.req0_grant, bus.req1_grant, bus.ram_we}, 0);
      step();
    end
    bus.arb_en = 1'b1;
    @(negedge clk);
`ifdef ARB_FIXED_PRIO_EN
    chk("t4_en_grant", {30'd0, bus.req1_grant, bus.req0_grant}, 32'h1);
`else
    chk("t4_en_grant", {30'd0, bus.req1_grant, bus.req0_grant}, 32'h2);
`endif
    step();
    idle_reqs();
    // a read granted just before arb_en falls still completes
    set_req(0, 1'b0, 13'h0005, 16'h0, 16'h0);
    @(negedge clk);
    chk("t4_we_done", {31'd0, bus.ram_we}, 1);
    chk("t4_rgrant0", {31'd0, bus.req0_grant}, 1);
    push_rd(1'b0, 16'hBEEF);
    step();
    bus.arb_en = 1'b0;
    idle_reqs();
    step(); step(); step();
    bus.arb_en = 1'b1;

    // reset while a read is in flight
    set_req(0, 1'b0, 13'h0005, 16'h0, 16'h0);
    @(negedge clk);
    chk("t5_grant0", {31'd0, bus.req0_grant}, 1);
    step();
    idle_reqs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_pre_raddr", {19'd0, bus.ram_raddr}, 32'h5);
    step();
    @(negedge clk);
    chk("t5_rvalid0", {31'd0, bus.req0_rvalid}, 0);
    chk("t5_ram_zero", {bus.ram_raddr, bus.ram_waddr} | {bus.ram_wdata, bus.ram_wmask}, 0);
    chk("t5_ram_we", {31'd0, bus.ram_we}, 0);
    step();
    rst_n = 1'b1;
    step();

    // withdrawn request from the loser of arbitration
    set_req(0, 1'b0, 13'h0005, 16'h0, 16'h0);
    @(negedge clk);
    chk("t6_first0", {31'd0, bus.req0_grant}, 1);
    push_rd(1'b0, 16'hBEEF);
    step();
    set_req(0, 1'b1, 13'h0200, 16'hDEAD, 16'h0000);
    set_req(1, 1'b0, 13'h0006, 16'h0, 16'h0);
`ifdef ARB_FIXED_PRIO_EN
    bus.arb_en = 1'b0;
    @(negedge clk);
    chk("t6_hold0", {30'd0, bus.req1_grant, bus.req0_grant}, 0);
    step();
    bus.arb_en = 1'b1;
    bus.req0_valid = 1'b0;
    @(negedge clk);
    chk("t6_win1", {30'd0, bus.req1_grant, bus.req0_grant}, 32'h2);
    push_rd(1'b1, 16'h1234);
`else
    @(negedge clk);
    chk("t6_win1", {30'd0, bus.req1_grant, bus.req0_grant}, 32'h2);
    push_rd(1'b1, 16'h1234);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    chk("t6_withdrawn", {30'd0, bus.req1_grant, bus.req0_grant}, 0);
`endif
    step();
    idle_reqs();
    @(negedge clk);
    chk("t6_no_we_a", {31'd0, bus.ram_we}, 0);
    step();
    @(negedge clk);
    chk("t6_no_we_b", {31'd0, bus.ram_we}, 0);
    step();
    // address 0x0200 must still hold its initial zero
    set_req(0, 1'b0, 13'h0200, 16'h0, 16'h0);
    @(negedge clk);
    chk("t6_probe_grant", {31'd0, bus.req0_grant}, 1);
    push_rd(1'b0, 16'h0000);
    step();
    idle_reqs();
    for (int k = 0; k < 5; k++) step();

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-003 SHALL have port arb_en, input, 1, high permits grants; low blocks all new grants.
REQ-004 SHALL have ports reqN_valid (N=0,1), input, 1, requester N presents an access.
REQ-005 SHALL have ports reqN_we, input, 1, 1=write, 0=read.
REQ-006 SHALL have ports reqN_addr, input, 13, word address.
REQ-007 SHALL have ports reqN_wdata, input, 16, write data.
REQ-008 SHALL have ports reqN_wmask, input, 16, per-bit write mask, 0=bit written.
REQ-009 SHALL have ports reqN_grant, output, 1, combinational; access accepted this cycle.
REQ-010 SHALL have ports reqN_rvalid, output, 1, registered; read data for N valid this cycle.
REQ-011 SHALL have port rd_data, output, 16, pass-through of ram_rdata, meaningful only with an rvalid.
REQ-012 SHALL have ports ram_raddr/ram_waddr, output, 13 each; ram_we, output, 1; ram_wdata, output, 16; ram_wmask, output, 16; all registered.
REQ-013 SHALL have port ram_rdata, input, 16, RAM read data, valid one cycle after ram_raddr is presented.

Function
REQ-014 SHALL grant at most one requester per cycle; reqN_grant=1 only when reqN_valid=1 and arb_en=1.
REQ-015 SHALL, with one valid requester, grant it in the same cycle.
REQ-016 SHALL, with both valid, grant the requester not granted most recently (round-robin pointer last_grant, updated on every grant).
REQ-017 SHALL require requesters to hold valid, we, addr, wdata and wmask stable until grant; a deasserted valid before grant is a withdrawn request, no side effect.
REQ-018 SHALL register a granted access (cycle T) onto the RAM port in cycle T+1: write -> ram_we=1, ram_waddr/ram_wdata/ram_wmask from requester; read -> ram_raddr from requester, ram_we=0.
REQ-019 SHALL drive ram_we=0 in every cycle T+1 that follows a cycle T with no write grant; ram_raddr, ram_waddr, ram_wdata and ram_wmask hold their last values when not updated.
REQ-020 SHALL assert reqN_rvalid for exactly one cycle, in cycle T+2, for a read granted to N in cycle T; writes produce no rvalid.
REQ-021 SHALL sustain one grant per cycle back-to-back; reads granted in T and T+1 yield rvalids in T+2 and T+3 in grant order.
REQ-022 SHALL guarantee a read granted in T+1 after a write to the same address granted in T returns the new data (write lands at end of T+1, read samples at end of T+2).
REQ-023 SHALL, when arb_en falls, still complete every access granted before the fall (RAM write, rvalid) on schedule.
REQ-024 SHALL provide no backpressure on rvalid; the requester must accept data in the rvalid cycle.

Reset
REQ-025 SHALL, on rst_n=0 at a clock edge, clear ram_we, reqN_rvalid, the in-flight pipeline tags, ram_raddr, ram_waddr, ram_wdata and ram_wmask to 0, and set last_grant=1 so requester 0 wins the first contention.
REQ-026 SHALL, while rst_n=0, hold reqN_grant=0 regardless of inputs.
REQ-027 SHALL discard accesses in flight when reset is asserted mid-operation: no RAM write after the reset edge, no rvalid until a new grant.

Configuration
REQ-028 SHALL, with macro ARB_FIXED_PRIO_EN defined, replace round-robin by fixed priority: requester 0 always wins contention, last_grant unused.
REQ-029 SHALL, without ARB_FIXED_PRIO_EN, use round-robin per REQ-016; all other behaviour identical.

Verification
REQ-030 SHALL test: reset, then req0 read addr 0x0005 alone, RAM word 0x5 = 0xBEEF -> grant0 in T, ram_raddr=0x0005 in T+1, rvalid0=1 and rd_data=0xBEEF in T+2.
REQ-031 SHALL test: both valid continuously for 4 cycles after reset -> grants 0,1,0,1 (round-robin); with ARB_FIXED_PRIO_EN -> 0,0,0,0.
REQ-032 SHALL test: req1 write addr 0x1FFF data 0xA5A5 mask 0x0000 in T, req0 read 0x1FFF in T+1 -> rvalid0 in T+3 with rd_data=0xA5A5.
REQ-033 SHALL test: arb_en=0 with both valid for 10 cycles -> no grants, ram_we=0 throughout; arb_en=1 -> grant within the same cycle.
REQ-034 SHALL test: read granted in T, rst_n=0 in T+1 -> no rvalid in T+2, all RAM-side outputs 0 after the reset edge.
REQ-035 SHALL test: req0 valid deasserted before grant while req1 holds priority -> no access for req0, no ram_we, no rvalid0.
